// File: rtl/sort_loader.sv
// Packs a serial sample stream into 4-sample frames and issues each frame to the
// sort core as two pairs, with a tag line aligned to the core's result latency.
module sort_loader #(
    parameter int unsigned    WIDTH    = 32,
    parameter logic [WIDTH-1:0] PAD    = '0,
    parameter int unsigned    CORE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sel,
    output logic             frame_valid,
    output logic [2:0]       frame_n
);

    localparam int unsigned FRAME = 4;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE0,
        ST_ISSUE1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [WIDTH-1:0]     r_c [FRAME];
    logic [CNT_W-1:0]     r_ccnt;
    logic                 r_closed;

    logic [WIDTH-1:0]     r_q [FRAME];
    logic [CNT_W-1:0]     r_qn;

    logic                 r_tag_v [CORE_LAT+1];
    logic [CNT_W-1:0]     r_tag_n [CORE_LAT+1];

    logic                 w_accept;
    logic                 w_handoff;

    assign s_ready   = !r_closed;
    assign w_accept  = s_valid && !r_closed;
    assign w_handoff = r_closed && (r_state == ST_IDLE || r_state == ST_ISSUE1);

    // Collect bank: fills while the issue bank drains, frozen once closed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FRAME); i++) begin
                r_c[i] <= '0;
            end
            r_ccnt   <= '0;
            r_closed <= 1'b0;
        end else if (w_handoff) begin
            r_ccnt   <= '0;
            r_closed <= 1'b0;
        end else if (w_accept) begin
            r_c[r_ccnt[1:0]] <= s_data;
            r_ccnt           <= r_ccnt + CNT_W'(1);
            if (r_ccnt == CNT_W'(FRAME - 1) || s_last) begin
                r_closed <= 1'b1;
            end
        end
    end

    // Issue bank: slots beyond the real sample count are padded, not left stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FRAME); i++) begin
                r_q[i] <= '0;
            end
            r_qn <= '0;
        end else if (w_handoff) begin
            for (int i = 0; i < int'(FRAME); i++) begin
                r_q[i] <= (CNT_W'(i) < r_ccnt) ? r_c[i] : PAD;
            end
            r_qn <= r_ccnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        a            = '0;
        b            = '0;
        sel          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_handoff) begin
                    w_next_state = ST_ISSUE0;
                end
            end
            ST_ISSUE0: begin
                a            = r_q[0];
                b            = r_q[1];
                sel          = 1'b0;
                w_next_state = ST_ISSUE1;
            end
            ST_ISSUE1: begin
                a            = r_q[2];
                b            = r_q[3];
                sel          = 1'b1;
                w_next_state = w_handoff ? ST_ISSUE0 : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Tag enters at the core's pair-0 capture edge and exits with its result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= int'(CORE_LAT); i++) begin
                r_tag_v[i] <= 1'b0;
                r_tag_n[i] <= '0;
            end
        end else begin
            r_tag_v[0] <= (r_state == ST_ISSUE0);
            r_tag_n[0] <= (r_state == ST_ISSUE0) ? r_qn : '0;
            for (int i = 1; i <= int'(CORE_LAT); i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_n[i] <= r_tag_n[i-1];
            end
        end
    end

    assign frame_valid = r_tag_v[CORE_LAT];
    assign frame_n     = r_tag_n[CORE_LAT];

endmodule

// File: tb/tb_sort_loader.sv
// Bench for sort_loader: directed vector table, corner sequences and a random
// stream checked by a frame-level reference model.
module tb_sort_loader;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CORE_LAT = 4;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             frame_valid;
    logic [2:0]       frame_n;

    sort_loader #(.WIDTH(WIDTH), .PAD('0), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .a(a), .b(b), .sel(sel),
        .frame_valid(frame_valid), .frame_n(frame_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frames formed from accepted samples, matched against issued pairs.
    typedef struct {
        logic [WIDTH-1:0] v [4];
        int               n;
    } frame_t;
    typedef struct {
        int cyc;
        int n;
    } tag_t;

    logic [WIDTH-1:0] part[$];
    frame_t           exp_frames[$];
    tag_t             exp_tags[$];
    frame_t           mon_f;
    tag_t             mon_t;
    logic [WIDTH-1:0] prev_a = '0;
    logic [WIDTH-1:0] prev_b = '0;
    logic             prev_sel = 1'b0;
    logic             sel_hist [4096];
    logic             fv_hist  [4096];

    always @(negedge clk) begin
        sel_hist[cyc % 4096] = sel;
        fv_hist[cyc % 4096]  = frame_valid;
        if (!rst) begin
            part.delete();
            exp_frames.delete();
            exp_tags.delete();
            prev_sel = 1'b0;
        end else begin
            if (s_valid && s_ready) begin
                part.push_back(s_data);
                if (part.size() == 4 || s_last) begin
                    mon_f.n = part.size();
                    for (int i = 0; i < 4; i++) begin
                        mon_f.v[i] = (i < part.size()) ? part[i] : '0;
                    end
                    exp_frames.push_back(mon_f);
                    part.delete();
                end
            end
            if (sel) begin
                chk("issue1_after_issue0", 64'(prev_sel), 64'(0));
                if (exp_frames.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got a=%0h b=%0h expected no frame", a, b);
                end else begin
                    mon_f = exp_frames.pop_front();
                    chk("mon_pair0_a", 64'(prev_a), 64'(mon_f.v[0]));
                    chk("mon_pair0_b", 64'(prev_b), 64'(mon_f.v[1]));
                    chk("mon_pair1_a", 64'(a), 64'(mon_f.v[2]));
                    chk("mon_pair1_b", 64'(b), 64'(mon_f.v[3]));
                    mon_t.cyc = cyc + int'(CORE_LAT);
                    mon_t.n   = mon_f.n;
                    exp_tags.push_back(mon_t);
                end
            end
            if (exp_tags.size() > 0 && exp_tags[0].cyc == cyc) begin
                mon_t = exp_tags.pop_front();
                chk("mon_frame_valid", 64'(frame_valid), 64'(1));
                chk("mon_frame_n", 64'(frame_n), 64'(mon_t.n));
            end else begin
                chk("mon_no_frame_valid", 64'(frame_valid), 64'(0));
            end
            prev_sel = sel;
        end
        prev_a = a;
        prev_b = b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic last, input logic keep);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && guard < 100) begin
            stalls++;
            tick();
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected 1", guard);
        end
        tick();
        if (!keep) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    typedef struct {
        int               len;
        logic             use_last;
        logic [WIDTH-1:0] d [4];
        logic [2:0]       exp_n;
        logic [WIDTH-1:0] ea0, eb0, ea1, eb1;
    } vec_t;

    vec_t vecs [5];

    function automatic void set_vec(input int idx, input int len, input logic ul,
                                    input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                    input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3,
                                    input logic [2:0] n,
                                    input logic [WIDTH-1:0] ea0, input logic [WIDTH-1:0] eb0,
                                    input logic [WIDTH-1:0] ea1, input logic [WIDTH-1:0] eb1);
        vecs[idx].len      = len;
        vecs[idx].use_last = ul;
        vecs[idx].d[0]     = d0;
        vecs[idx].d[1]     = d1;
        vecs[idx].d[2]     = d2;
        vecs[idx].d[3]     = d3;
        vecs[idx].exp_n    = n;
        vecs[idx].ea0      = ea0;
        vecs[idx].eb0      = eb0;
        vecs[idx].ea1      = ea1;
        vecs[idx].eb1      = eb1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k1;
        int start;
        int pulses;
        int len;
        logic ul;
        logic keep;

        set_vec(0, 4, 1'b0, 7, 3, 9, 1, 3'd4, 7, 3, 9, 1);
        set_vec(1, 1, 1'b1, 5, 0, 0, 0, 3'd1, 5, 0, 0, 0);
        set_vec(2, 4, 1'b1, 2, 4, 6, 8, 3'd4, 2, 4, 6, 8);
        set_vec(3, 3, 1'b1, 10, 20, 30, 0, 3'd3, 10, 20, 30, 0);
        set_vec(4, 2, 1'b1, 32'hFFFF_FFFF, 1, 0, 0, 3'd2, 32'hFFFF_FFFF, 1, 0, 0);

        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        #2;
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        chk("rst_a", 64'(a), 64'(0));
        chk("rst_b", 64'(b), 64'(0));
        chk("rst_sel", 64'(sel), 64'(0));
        chk("rst_frame_valid", 64'(frame_valid), 64'(0));
        chk("rst_frame_n", 64'(frame_n), 64'(0));
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // Directed frames with exact edge-by-edge timing.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].len; i++) begin
                send(vecs[v].d[i], vecs[v].use_last && (i == vecs[v].len - 1),
                     i < vecs[v].len - 1);
            end
            chk("vec_ready_drop", 64'(s_ready), 64'(0));
            chk("vec_idle_sel", 64'(sel), 64'(0));
            tick();
            chk("vec_ready_back", 64'(s_ready), 64'(1));
            chk("vec_p0_a", 64'(a), 64'(vecs[v].ea0));
            chk("vec_p0_b", 64'(b), 64'(vecs[v].eb0));
            chk("vec_p0_sel", 64'(sel), 64'(0));
            tick();
            chk("vec_p1_a", 64'(a), 64'(vecs[v].ea1));
            chk("vec_p1_b", 64'(b), 64'(vecs[v].eb1));
            chk("vec_p1_sel", 64'(sel), 64'(1));
            tick();
            chk("vec_back_idle_sel", 64'(sel), 64'(0));
            chk("vec_back_idle_a", 64'(a), 64'(0));
            repeat (3) tick();
            chk("vec_fv", 64'(frame_valid), 64'(1));
            chk("vec_fn", 64'(frame_n), 64'(vecs[v].exp_n));
            tick();
            chk("vec_fv_end", 64'(frame_valid), 64'(0));
            repeat (2) tick();
        end

        // Continuous stream of 12 samples.
        stalls = 0;
        start  = cyc;
        for (int i = 0; i < 12; i++) begin
            send(WIDTH'(100 + i), 1'b0, i < 11);
        end
        chk("stream_stalls", 64'(stalls), 64'(2));
        chk("stream_last_ready", 64'(s_ready), 64'(0));
        repeat (15) tick();
        pulses = 0;
        for (int c = start; c <= cyc; c++) begin
            if (fv_hist[c % 4096]) pulses++;
        end
        chk("stream_pulses", 64'(pulses), 64'(3));

        // Minimum spacing: three single-sample frames.
        send(1, 1'b1, 1'b1);
        k1 = cyc;
        send(2, 1'b1, 1'b1);
        send(3, 1'b1, 1'b0);
        repeat (14) tick();
        for (int j = 1; j <= 6; j++) begin
            chk("minsp_sel", 64'(sel_hist[(k1 + j) % 4096]), 64'((j % 2) == 0));
        end
        chk("minsp_sel_idle", 64'(sel_hist[(k1 + 7) % 4096]), 64'(0));
        for (int j = 6; j <= 10; j++) begin
            chk("minsp_fv", 64'(fv_hist[(k1 + j) % 4096]), 64'((j % 2) == 0));
        end

        // Upstream stall between samples 2 and 3.
        send(20, 1'b0, 1'b0);
        send(21, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_no_issue_sel", 64'(sel), 64'(0));
            chk("stall_no_issue_a", 64'(a), 64'(0));
        end
        send(22, 1'b0, 1'b1);
        send(23, 1'b0, 1'b0);
        chk("stall_ready_drop", 64'(s_ready), 64'(0));
        tick();
        chk("stall_p0_a", 64'(a), 64'(20));
        chk("stall_p0_b", 64'(b), 64'(21));
        tick();
        chk("stall_p1_a", 64'(a), 64'(22));
        chk("stall_p1_b", 64'(b), 64'(23));
        chk("stall_p1_sel", 64'(sel), 64'(1));
        repeat (8) tick();

        // Reset asserted while in ISSUE1.
        for (int i = 0; i < 4; i++) send(WIDTH'(30 + i), 1'b0, i < 3);
        repeat (2) tick();
        chk("mid_rst_in_issue1", 64'(sel), 64'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_s_ready", 64'(s_ready), 64'(1));
        chk("mid_rst_sel", 64'(sel), 64'(0));
        chk("mid_rst_a", 64'(a), 64'(0));
        chk("mid_rst_b", 64'(b), 64'(0));
        chk("mid_rst_fv", 64'(frame_valid), 64'(0));
        chk("mid_rst_fn", 64'(frame_n), 64'(0));
        tick();
        rst = 1'b1;
        repeat (10) tick();
        send(40, 1'b0, 1'b1);
        send(41, 1'b1, 1'b0);
        tick();
        chk("post_rst_p0_a", 64'(a), 64'(40));
        chk("post_rst_p0_b", 64'(b), 64'(41));
        tick();
        chk("post_rst_p1_a", 64'(a), 64'(0));
        chk("post_rst_p1_sel", 64'(sel), 64'(1));
        repeat (4) tick();
        chk("post_rst_fv", 64'(frame_valid), 64'(1));
        chk("post_rst_fn", 64'(frame_n), 64'(2));
        repeat (4) tick();

        // Random stream checked by the reference model.
        for (int f = 0; f < 80; f++) begin
            len = int'($urandom_range(1, 4));
            ul  = (len < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                keep = 1'($urandom_range(0, 1));
                send($urandom, ul && (i == len - 1), keep);
                if (!keep) repeat ($urandom_range(0, 3)) tick();
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (20) tick();
        chk("drain_frames_empty", 64'(exp_frames.size()), 64'(0));
        chk("drain_tags_empty", 64'(exp_tags.size()), 64'(0));
        chk("drain_partial_empty", 64'(part.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
